gbf_refill_ctrl: RTL and testbench

//  Upstream refill engine for accelerator_port's double-buffered global buffers (actv GBF1/2, wgt GBF1/2).

---
 rtl/gbf_refill_ctrl.sv | 142 ++++++++++++++
 tb/tb_gbf_refill_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbf_refill_ctrl.sv
// Refill engine for the double-buffered global buffers: round-robin over four need_data
// edges, one burst read request per grant, GBF_DEPTH beats written into the chosen buffer.
module gbf_refill_ctrl #(
   parameter int GBF_DATA_BITWIDTH = 256,
   parameter int GBF_ADDR_BITWIDTH = 5,
   parameter int GBF_DEPTH         = 32
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           actv_gbf1_need_data,
   input  logic                           actv_gbf2_need_data,
   input  logic                           wgt_gbf1_need_data,
   input  logic                           wgt_gbf2_need_data,
   output logic                           rd_req_valid,
   input  logic                           rd_req_ready,
   output logic [1:0]                     rd_req_tgt,
   output logic [GBF_ADDR_BITWIDTH:0]     rd_req_len,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [GBF_DATA_BITWIDTH-1:0]   s_data,
   output logic [3:0]                     gbf_w_en,
   output logic [GBF_ADDR_BITWIDTH-1:0]   gbf_w_addr,
   output logic [GBF_DATA_BITWIDTH-1:0]   gbf_w_data,
   output logic [3:0]                     fill_done,
   output logic                           busy
);

   localparam int LEN_W = GBF_ADDR_BITWIDTH + 1;
   localparam logic [GBF_ADDR_BITWIDTH-1:0] LAST_BEAT = GBF_ADDR_BITWIDTH'(GBF_DEPTH - 1);
   localparam logic [LEN_W-1:0]             BURST_LEN = LEN_W'(GBF_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

   state_t                          state_q, state_d;
   logic [3:0]                      hist_q, pend_q, pend_d;
   logic [1:0]                      tgt_q, tgt_d, rr_q, rr_d;
   logic [GBF_ADDR_BITWIDTH-1:0]    beat_q, beat_d;
   logic [3:0]                      w_en_q, w_en_d, done_q, done_d;
   logic [GBF_ADDR_BITWIDTH-1:0]    w_addr_q;
   logic [GBF_DATA_BITWIDTH-1:0]    w_data_q;

   logic [3:0] need, rise, tgt_oh, svc_mask;
   logic       beat_hs;
   logic       grant_vld;
   logic [1:0] grant_idx, idx;

   assign need     = {wgt_gbf2_need_data, wgt_gbf1_need_data, actv_gbf2_need_data, actv_gbf1_need_data};
   assign rise     = need & ~hist_q;
   assign tgt_oh   = 4'b0001 << tgt_q;
   assign svc_mask = (state_q != IDLE) ? tgt_oh : 4'b0000;
   assign beat_hs  = (state_q == FILL) && s_valid;

   // Descending scan so the nearest pending target at or after rr_q wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = rr_q;
      idx       = rr_q;
      for (int k = 3; k >= 0; k--) begin
         idx = rr_q + 2'(k);
         if (pend_q[idx]) begin
            grant_vld = 1'b1;
            grant_idx = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      rr_d    = rr_q;
      beat_d  = beat_q;
      pend_d  = pend_q | (rise & ~svc_mask);
      unique case (state_q)
         IDLE: begin
            if (grant_vld) begin
               state_d = REQ;
               tgt_d   = grant_idx;
               rr_d    = grant_idx + 2'd1;
               pend_d  = pend_d & ~(4'b0001 << grant_idx);
            end
         end
         REQ: begin
            if (rd_req_ready) state_d = FILL;
         end
         FILL: begin
            if (s_valid) begin
               if (beat_q == LAST_BEAT) begin
                  beat_d  = '0;
                  state_d = DONE;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // fill_done is registered off DONE so it lands one cycle after the final write.
   assign w_en_d = beat_hs ? tgt_oh : 4'b0000;
   assign done_d = (state_q == DONE) ? tgt_oh : 4'b0000;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         hist_q   <= '0;
         pend_q   <= '0;
         tgt_q    <= '0;
         rr_q     <= '0;
         beat_q   <= '0;
         w_en_q   <= '0;
         done_q   <= '0;
         w_addr_q <= '0;
         w_data_q <= '0;
      end else begin
         state_q <= state_d;
         hist_q  <= need;
         pend_q  <= pend_d;
         tgt_q   <= tgt_d;
         rr_q    <= rr_d;
         beat_q  <= beat_d;
         w_en_q  <= w_en_d;
         done_q  <= done_d;
         if (beat_hs) begin
            w_addr_q <= beat_q;
            w_data_q <= s_data;
         end
      end
   end

   assign rd_req_valid = (state_q == REQ);
   assign rd_req_tgt   = tgt_q;
   assign rd_req_len   = rd_req_valid ? BURST_LEN : '0;
   assign s_ready      = (state_q == FILL);
   assign gbf_w_en     = w_en_q;
   assign gbf_w_addr   = w_addr_q;
   assign gbf_w_data   = w_data_q;
   assign fill_done    = done_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_gbf_refill_ctrl.sv
// Bench for gbf_refill_ctrl: directed bursts, expected requests/writes/done pulses queued
// in order and checked by an independent monitor on the falling edge.
module tb_gbf_refill_ctrl;

   localparam int DW    = 256;
   localparam int AW    = 5;
   localparam int DEPTH = 32;
   localparam int BOUND = 300;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    need;
   logic          rd_req_valid, rd_req_ready;
   logic [1:0]    rd_req_tgt;
   logic [AW:0]   rd_req_len;
   logic          s_valid, s_ready;
   logic [DW-1:0] s_data;
   logic [3:0]    gbf_w_en;
   logic [AW-1:0] gbf_w_addr;
   logic [DW-1:0] gbf_w_data;
   logic [3:0]    fill_done;
   logic          busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int            kind;   // 0 request, 1 write, 2 done
      logic [3:0]    oh;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            tgt;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;

   gbf_refill_ctrl #(.GBF_DATA_BITWIDTH(DW), .GBF_ADDR_BITWIDTH(AW), .GBF_DEPTH(DEPTH)) dut (
      .clk                 (clk),
      .reset               (rst_n),
      .actv_gbf1_need_data (need[0]),
      .actv_gbf2_need_data (need[1]),
      .wgt_gbf1_need_data  (need[2]),
      .wgt_gbf2_need_data  (need[3]),
      .rd_req_valid        (rd_req_valid),
      .rd_req_ready        (rd_req_ready),
      .rd_req_tgt          (rd_req_tgt),
      .rd_req_len          (rd_req_len),
      .s_valid             (s_valid),
      .s_ready             (s_ready),
      .s_data              (s_data),
      .gbf_w_en            (gbf_w_en),
      .gbf_w_addr          (gbf_w_addr),
      .gbf_w_data          (gbf_w_data),
      .fill_done           (fill_done),
      .busy                (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] beat_data(input int tgt, input int b);
      return (DW'(tgt) << 248) | DW'(b);
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   task automatic push_burst(input int tgt, input int nbeats, input bit with_done);
      ev_t e;
      e.kind = 0; e.tgt = tgt; e.oh = 4'b0001 << tgt; e.addr = '0; e.data = '0;
      exp_q.push_back(e);
      for (int b = 0; b < nbeats; b++) begin
         e.kind = 1; e.addr = AW'(b); e.data = beat_data(tgt, b);
         exp_q.push_back(e);
      end
      if (with_done) begin
         e.kind = 2; e.addr = '0; e.data = '0;
         exp_q.push_back(e);
      end
   endtask

   // Entered and left at posedge+1; serves one request then nbeats beats.
   task automatic serve(input int tgt, input int req_delay, input bit gap, input int nbeats);
      int n;
      n = 0;
      while (!rd_req_valid && n < BOUND) begin @(posedge clk); #1; n++; end
      if (!rd_req_valid) begin
         checks++; errors++;
         $display("FAIL req_timeout tgt%0d: got no rd_req_valid, required one within %0d clks", tgt, BOUND);
         return;
      end
      repeat (req_delay) begin @(posedge clk); #1; end
      if (req_delay > 0) chk($sformatf("req_held_%0d", tgt), DW'(rd_req_valid), DW'(1));
      rd_req_ready = 1'b1;
      @(posedge clk); #1;
      rd_req_ready = 1'b0;
      for (int b = 0; b < nbeats; b++) begin
         s_valid = 1'b1;
         s_data  = beat_data(tgt, b);
         n = 0;
         while (!s_ready && n < BOUND) begin @(posedge clk); #1; n++; end
         if (!s_ready) begin
            checks++; errors++; s_valid = 1'b0;
            $display("FAIL sready_timeout tgt%0d beat%0d: got s_ready=0, required 1", tgt, b);
            return;
         end
         @(posedge clk); #1;
         if (gap) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rd_req_valid"}, DW'(rd_req_valid), '0);
      chk({tag, "_rd_req_tgt"},   DW'(rd_req_tgt),   '0);
      chk({tag, "_rd_req_len"},   DW'(rd_req_len),   '0);
      chk({tag, "_s_ready"},      DW'(s_ready),      '0);
      chk({tag, "_gbf_w_en"},     DW'(gbf_w_en),     '0);
      chk({tag, "_gbf_w_addr"},   DW'(gbf_w_addr),   '0);
      chk({tag, "_gbf_w_data"},   gbf_w_data,        '0);
      chk({tag, "_fill_done"},    DW'(fill_done),    '0);
      chk({tag, "_busy"},         DW'(busy),         '0);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      idle_cycles(3);
      rst_n = 1'b1;
   endtask

   // Scoreboard monitor: every DUT event must match the head of the expected queue.
   always @(negedge clk) begin
      if (gbf_w_en != 4'b0000 && fill_done != 4'b0000) begin
         checks++; errors++;
         $display("FAIL done_with_write: got fill_done=%b with gbf_w_en=%b, required done after last write", fill_done, gbf_w_en);
      end
      if (rd_req_valid && rd_req_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL req_unexpected: got tgt=%0d, required no request", rd_req_tgt);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.kind != 0 || int'(rd_req_tgt) != mon_e.tgt || rd_req_len != (AW+1)'(DEPTH)) begin
               errors++;
               $display("FAIL req: got tgt=%0d len=%0d, required event kind=%0d tgt=%0d len=%0d",
                        rd_req_tgt, rd_req_len, mon_e.kind, mon_e.tgt, DEPTH);
            end
         end
      end
      if (gbf_w_en != 4'b0000) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: got en=%b addr=%0d, required no write", gbf_w_en, gbf_w_addr);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.kind != 1 || gbf_w_en != mon_e.oh || gbf_w_addr != mon_e.addr || gbf_w_data != mon_e.data) begin
               errors++;
               $display("FAIL write: got en=%b addr=%0d data=%0h, required kind=%0d en=%b addr=%0d data=%0h",
                        gbf_w_en, gbf_w_addr, gbf_w_data, mon_e.kind, mon_e.oh, mon_e.addr, mon_e.data);
            end
         end
      end
      if (fill_done != 4'b0000) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: got fill_done=%b, required none", fill_done);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.kind != 2 || fill_done != mon_e.oh) begin
               errors++;
               $display("FAIL done: got fill_done=%b, required kind=%0d fill_done=%b", fill_done, mon_e.kind, mon_e.oh);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; need = 4'b0000; rd_req_ready = 1'b0; s_valid = 1'b0; s_data = '0;

      // T1: reset held three clocks with idle inputs
      idle_cycles(3);
      check_all_zero("t1");
      rst_n = 1'b1;
      idle_cycles(2);
      chk("t1_idle_busy", DW'(busy), '0);

      // T2: single refill of actv_gbf1
      push_burst(0, DEPTH, 1'b1);
      need[0] = 1'b1;
      serve(0, 0, 1'b0, DEPTH);
      idle_cycles(3);
      chk("t2_drained", DW'(exp_q.size()), '0);
      need[0] = 1'b0;
      idle_cycles(2);

      // T3: four simultaneous edges from rr_ptr=0, then edges on 2 and 0
      pulse_reset();
      for (int t = 0; t < 4; t++) push_burst(t, DEPTH, 1'b1);
      need = 4'b1111;
      for (int t = 0; t < 4; t++) serve(t, 0, 1'b0, DEPTH);
      idle_cycles(3);
      chk("t3a_drained", DW'(exp_q.size()), '0);
      need = 4'b0000;
      idle_cycles(3);
      push_burst(0, DEPTH, 1'b1);
      push_burst(2, DEPTH, 1'b1);
      need = 4'b0101;
      serve(0, 0, 1'b0, DEPTH);
      serve(2, 0, 1'b0, DEPTH);
      idle_cycles(3);
      chk("t3b_drained", DW'(exp_q.size()), '0);
      need = 4'b0000;
      idle_cycles(3);

      // T4: delayed request acceptance and alternate-cycle beats
      push_burst(1, DEPTH, 1'b1);
      need[1] = 1'b1;
      serve(1, 5, 1'b1, DEPTH);
      idle_cycles(3);
      chk("t4_drained", DW'(exp_q.size()), '0);
      need[1] = 1'b0;
      idle_cycles(3);

      // T5: reset at beat 10 of a wgt_gbf1 fill, level kept high
      push_burst(2, 10, 1'b0);
      need[2] = 1'b1;
      serve(2, 0, 1'b0, 10);
      @(negedge clk); #1;
      chk("t5_pre_drained", DW'(exp_q.size()), '0);
      rst_n = 1'b0;
      #1;
      check_all_zero("t5");
      @(posedge clk); #1;
      @(posedge clk); #1;
      push_burst(2, DEPTH, 1'b1);
      rst_n = 1'b1;
      serve(2, 0, 1'b0, DEPTH);
      idle_cycles(20);
      chk("t5_drained", DW'(exp_q.size()), '0);

      // T6: wgt_gbf2 level held long after its fill completes
      push_burst(3, DEPTH, 1'b1);
      need[3] = 1'b1;
      serve(3, 0, 1'b0, DEPTH);
      idle_cycles(200);
      chk("t6_drained", DW'(exp_q.size()), '0);
      chk("t6_busy", DW'(busy), '0);
      chk("t6_req_valid", DW'(rd_req_valid), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
